rx_top: RTL and testbench

UART receiver, the mirror of the transmit path. Recovers frames from the serial line with an oversampled bit clock and checks parity and stop bit. Presents each received word with a one-cycle valid strobe and error flags. Frame format matches the transmitter: start(0), DATA_WIDTH data bits LSB first, even parity bit, stop(1); idle line is high.

---
 rtl/rx_pkg.sv | 15 +
 rtl/rx_sipo.sv | 20 ++
 rtl/rx_top.sv | 167 ++++++++++++++++
 tb/tb_rx_top.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared frame constants and receiver state encoding for the UART receive path.
package rx_pkg;

    localparam int unsigned RX_DATA_WIDTH = 8;
    localparam int unsigned RX_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_sipo.sv
// Serial-in parallel-out register: shifts right so the first bit received lands in the LSB.
module rx_sipo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/rx_top.sv
// UART receiver: oversampled frame recovery with even-parity and stop-bit checking.
module rx_top
    import rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RX_DATA_WIDTH,
    parameter int unsigned OVERSAMPLE = RX_OVERSAMPLE
) (
    input  logic                  RX_CLK,
    input  logic                  RX_RST_N,
    input  logic                  RX_DATA,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  DATA_VALID,
    output logic                  PARITY_ERR,
    output logic                  FRAME_ERR,
    output logic                  RX_BUSY
);

    localparam int unsigned CW   = $clog2(OVERSAMPLE);
    localparam int unsigned BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned HALF = OVERSAMPLE / 2;

    logic [1:0]            sync_q;
    logic                  rx_s;
    rx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         idx_q, idx_d;
    logic                  armed_q, armed_d;
    logic                  stop_taken_q, stop_taken_d;
    logic                  par_q, par_d;
    logic                  stop_q, stop_d;
    logic                  shift_en;
    logic [DATA_WIDTH-1:0] sipo_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  valid_d, perr_d, ferr_d, busy_d;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge RX_CLK or negedge RX_RST_N) begin
        if (!RX_RST_N) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_DATA};
        end
    end
    assign rx_s = sync_q[1];

    rx_sipo #(.WIDTH(DATA_WIDTH)) u_sipo (
        .clk      (RX_CLK),
        .rst_n    (RX_RST_N),
        .shift_en (shift_en),
        .din      (rx_s),
        .q        (sipo_q)
    );

    always_ff @(posedge RX_CLK or negedge RX_RST_N) begin
        if (!RX_RST_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            armed_q      <= 1'b0;
            stop_taken_q <= 1'b0;
            par_q        <= 1'b0;
            stop_q       <= 1'b0;
            DATA_OUT     <= '0;
            DATA_VALID   <= 1'b0;
            PARITY_ERR   <= 1'b0;
            FRAME_ERR    <= 1'b0;
            RX_BUSY      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            armed_q      <= armed_d;
            stop_taken_q <= stop_taken_d;
            par_q        <= par_d;
            stop_q       <= stop_d;
            DATA_OUT     <= data_d;
            DATA_VALID   <= valid_d;
            PARITY_ERR   <= perr_d;
            FRAME_ERR    <= ferr_d;
            RX_BUSY      <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        armed_d      = armed_q;
        stop_taken_d = stop_taken_q;
        par_d        = par_q;
        stop_d       = stop_q;
        shift_en     = 1'b0;
        data_d       = DATA_OUT;
        valid_d      = 1'b0;
        perr_d       = PARITY_ERR;
        ferr_d       = FRAME_ERR;

        case (state_q)
            ST_IDLE: begin
                cnt_d        = '0;
                idx_d        = '0;
                stop_taken_d = 1'b0;
                // Armed only once the line is seen high, so a held-low break cannot restart.
                if (armed_q && !rx_s) begin
                    state_d = ST_START;
                    armed_d = 1'b0;
                end else if (rx_s) begin
                    armed_d = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CW'(OVERSAMPLE - 1)) begin
                    cnt_d    = '0;
                    shift_en = 1'b1;
                    if (idx_q == BW'(DATA_WIDTH - 1)) begin
                        idx_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == CW'(OVERSAMPLE - 1)) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                // Stop bit is captured first; results are published on the following cycle.
                if (stop_taken_q) begin
                    stop_taken_d = 1'b0;
                    state_d      = ST_IDLE;
                    valid_d      = 1'b1;
                    data_d       = sipo_q;
                    perr_d       = (^sipo_q) != par_q;
                    ferr_d       = !stop_q;
                end else if (cnt_q == CW'(OVERSAMPLE - 1)) begin
                    cnt_d        = '0;
                    stop_d       = rx_s;
                    stop_taken_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_rx_top.sv
// Directed bench for rx_top: a frame-level model queues expected words and strobe times.
module tb_rx_top;

    logic       clk;
    logic       rst_n;
    logic       rx_data;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   vcyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;

    // Start edge driven just after posedge P is detected at P+3; the strobe follows 169 cycles later.
    localparam int VALID_LAT = 172;

    rx_top dut (
        .RX_CLK     (clk),
        .RX_RST_N   (rst_n),
        .RX_DATA    (rx_data),
        .DATA_OUT   (data_out),
        .DATA_VALID (data_valid),
        .PARITY_ERR (parity_err),
        .FRAME_ERR  (frame_err),
        .RX_BUSY    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called right at a posedge; drives one full frame, returns at the posedge ending the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              output int start_cyc);
        exp_t e;
        #1;
        rx_data   = 1'b0;
        start_cyc = cyc;
        e.data = d;
        e.perr = ((^d) != par);
        e.ferr = !stop;
        e.cyc  = cyc + VALID_LAT;
        q.push_back(e);
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_data = d[i];
            repeat (16) @(posedge clk);
        end
        #1 rx_data = par;
        repeat (16) @(posedge clk);
        #1 rx_data = stop;
        repeat (16) @(posedge clk);
    endtask

    // Compare process: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (data_valid) begin
                check("valid_one_cycle", 32'(prev_valid), 32'd0);
                if (q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("data_out", 32'(data_out), 32'(e.data));
                    check("parity_err", 32'(parity_err), 32'(e.perr));
                    check("frame_err", 32'(frame_err), 32'(e.ferr));
                    check("valid_cycle", 32'(cyc), 32'(e.cyc));
                end
                vcyc.push_back(cyc);
            end
            prev_valid = data_valid;
        end
    end

    initial begin
        int s1, s2, nv;
        rst_n   = 1'b0;
        rx_data = 1'b1;
        #1;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // 1: clean 0xA5
        send_frame(8'hA5, 1'b0, 1'b1, s1);
        check("t1_data_lit", 32'(data_out), 32'hA5);
        check("t1_flags_lit", {30'd0, parity_err, frame_err}, 32'd0);
        check("t1_latency_lit", 32'(vcyc[$] - s1), 32'd172);
        check("t1_idle_busy", 32'(rx_busy), 32'd0);

        // 2: 5-cycle glitch, then a good 0x3C
        repeat (8) @(posedge clk);
        #1 rx_data = 1'b0;
        nv = vcyc.size();
        repeat (4) @(posedge clk);
        #1 check("t2_glitch_busy", 32'(rx_busy), 32'd1);
        repeat (1) @(posedge clk);
        #1 rx_data = 1'b1;
        repeat (16) @(posedge clk);
        #1 check("t2_glitch_idle", 32'(rx_busy), 32'd0);
        check("t2_no_valid", 32'(vcyc.size()), 32'(nv));
        @(posedge clk);
        send_frame(8'h3C, 1'b0, 1'b1, s1);
        check("t2_data_lit", 32'(data_out), 32'h3C);

        // 3: parity error
        repeat (8) @(posedge clk);
        send_frame(8'h3C, 1'b1, 1'b1, s1);
        check("t3_perr_lit", 32'(parity_err), 32'd1);
        check("t3_ferr_lit", 32'(frame_err), 32'd0);

        // 4: frame error then break held low for 3 bit periods
        repeat (8) @(posedge clk);
        send_frame(8'h81, 1'b0, 1'b0, s1);
        check("t4_ferr_lit", 32'(frame_err), 32'd1);
        nv = vcyc.size();
        repeat (48) @(posedge clk);
        #1 check("t4_break_busy", 32'(rx_busy), 32'd0);
        check("t4_break_no_valid", 32'(vcyc.size()), 32'(nv));
        rx_data = 1'b1;
        repeat (16) @(posedge clk);
        send_frame(8'h55, 1'b0, 1'b1, s1);
        check("t4_recover_ferr_lit", 32'(frame_err), 32'd0);

        // 5: back-to-back 0x00 then 0xFF
        repeat (8) @(posedge clk);
        send_frame(8'h00, 1'b0, 1'b1, s1);
        send_frame(8'hFF, 1'b0, 1'b1, s2);
        check("t5_gap_lit", 32'(vcyc[$] - vcyc[$-1]), 32'd176);
        check("t5_data_lit", 32'(data_out), 32'hFF);

        // 6: reset during data bit 3 of 0xC3
        repeat (8) @(posedge clk);
        #1 rx_data = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rx_data = (i < 2) ? 1'b1 : 1'b0;
            repeat ((i == 3) ? 8 : 16) @(posedge clk);
        end
        #1 check("t6_busy_before", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_data", 32'(data_out), 32'd0);
        check("t6_rst_flags", {29'd0, data_valid, parity_err, frame_err}, 32'd0);
        check("t6_rst_busy", 32'(rx_busy), 32'd0);
        rx_data = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, s1);
        check("t6_data_lit", 32'(data_out), 32'h5A);

        repeat (20) @(posedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
